// File: rtl/lsu_pkg.sv
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and RV32I funct3 encodings for the load/store
//               unit and its lane-alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_ILLEGAL  = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } lsu_err_e;

  // Load encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  // Store encodings
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // True when funct3 names a real RV32I access of the given direction.
  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    if (we) begin
      return (f3 == SB) || (f3 == SH) || (f3 == SW);
    end
    return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module      : lsu_align
// Description : Purely combinational lane logic: byte enables, replicated
//               store data, misaligned/illegal detection and load-data
//               extraction with sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            we_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      offset_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic            misaligned_o,
  output logic            illegal_o,
  output logic [XLEN-1:0] load_data_o
);

  logic [XLEN-1:0] w_lane;

  // Store side: size decode gives enables, lane replication and alignment.
  always_comb begin
    illegal_o    = !funct3_legal(we_i, funct3_i);
    misaligned_o = 1'b0;
    be_o         = 4'b0000;
    wdata_o      = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << offset_i;
        wdata_o = {(XLEN/8){wdata_i[7:0]}};
      end
      2'b01: begin
        be_o         = 4'b0011 << offset_i;
        wdata_o      = {(XLEN/16){wdata_i[15:0]}};
        misaligned_o = offset_i[0];
      end
      2'b10: begin
        be_o         = 4'b1111;
        misaligned_o = (offset_i != 2'b00);
      end
      default: begin
        be_o = 4'b0000;
      end
    endcase
  end

  // Load side: shift the addressed lane down, then extend by funct3.
  always_comb begin
    w_lane      = rdata_i >> {offset_i, 3'b000};
    load_data_o = w_lane;
    case (funct3_i)
      LB:      load_data_o = {{(XLEN-8){w_lane[7]}}, w_lane[7:0]};
      LH:      load_data_o = {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
      LBU:     load_data_o = {{(XLEN-8){1'b0}}, w_lane[7:0]};
      LHU:     load_data_o = {{(XLEN-16){1'b0}}, w_lane[15:0]};
      default: load_data_o = w_lane;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module      : load_store_unit
// Description : RV32I load/store unit between the EX/MEM register and a
//               variable-latency word-addressed data bus. Stalls the pipe
//               while a transaction is outstanding and reports errors.
//               Optional bus watchdog: define LSU_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid_i,
  input  logic            req_we_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  input  logic            kill_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            err_o,
  output logic [1:0]      err_code_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  lsu_state_e      state_q, state_d;
  logic            we_q, we_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      offset_q, offset_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  lsu_err_e        err_q, err_d;
  logic            kill_q, kill_d;

  logic            w_idle;
  logic            w_killed;
  logic            w_al_we;
  logic [2:0]      w_al_funct3;
  logic [1:0]      w_al_offset;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata;
  logic            w_misaligned;
  logic            w_illegal;
  logic            w_load_data_ok;
  logic [XLEN-1:0] w_load_data;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             w_expired;
  assign w_expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // While idle the aligner sees the live request; afterwards the latched one,
  // so the same instance serves both store packing and load extraction.
  assign w_idle      = (state_q == ST_IDLE);
  assign w_killed    = kill_q | kill_i;
  assign w_al_we     = w_idle ? req_we_i          : we_q;
  assign w_al_funct3 = w_idle ? req_funct3_i      : funct3_q;
  assign w_al_offset = w_idle ? req_addr_i[1:0]   : offset_q;
  assign w_load_data_ok = 1'b1;

  lsu_align #(
    .XLEN (XLEN)
  ) u_align (
    .we_i         (w_al_we),
    .funct3_i     (w_al_funct3),
    .offset_i     (w_al_offset),
    .wdata_i      (req_wdata_i),
    .rdata_i      (mem_rdata_i),
    .be_o         (w_be),
    .wdata_o      (w_wdata),
    .misaligned_o (w_misaligned),
    .illegal_o    (w_illegal),
    .load_data_o  (w_load_data)
  );

  // Next-state and transaction bookkeeping.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    offset_d = offset_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    kill_d   = kill_q | kill_i;
`ifdef LSU_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        kill_d = 1'b0;
        if (req_valid_i && !kill_i) begin
          rdata_d = '0;
          err_d   = ERR_NONE;
          if (w_illegal) begin
            err_d   = ERR_ILLEGAL;
            state_d = ST_RESP;
          end else if (w_misaligned) begin
            err_d   = ERR_MISALIGN;
            state_d = ST_RESP;
          end else begin
            we_d     = req_we_i;
            funct3_d = req_funct3_i;
            offset_d = req_addr_i[1:0];
            addr_d   = {req_addr_i[XLEN-1:2], 2'b00};
            be_d     = w_be;
            wdata_d  = w_wdata;
            state_d  = ST_REQ;
`ifdef LSU_TIMEOUT_EN
            cnt_d    = '0;
`endif
          end
        end
      end
      ST_REQ: begin
        if (mem_gnt_i) begin
          if (we_q) begin
            state_d = w_killed ? ST_IDLE : ST_RESP;
          end else begin
            state_d = ST_WAIT_R;
`ifdef LSU_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
`ifdef LSU_TIMEOUT_EN
        end else if (w_expired) begin
          err_d   = ERR_TIMEOUT;
          state_d = w_killed ? ST_IDLE : ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      ST_WAIT_R: begin
        if (mem_rvalid_i && w_load_data_ok) begin
          rdata_d = w_load_data;
          state_d = w_killed ? ST_IDLE : ST_RESP;
`ifdef LSU_TIMEOUT_EN
        end else if (w_expired) begin
          err_d   = ERR_TIMEOUT;
          state_d = w_killed ? ST_IDLE : ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and transaction registers; reset abandons any bus transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      offset_q <= 2'b00;
      addr_q   <= '0;
      be_q     <= 4'b0000;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= ERR_NONE;
      kill_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      offset_q <= offset_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      kill_q   <= kill_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  // Bus side only shows the latched transfer while it is being requested.
  assign mem_req_o   = (state_q == ST_REQ);
  assign mem_we_o    = mem_req_o & we_q;
  assign mem_addr_o  = mem_req_o ? addr_q  : '0;
  assign mem_be_o    = mem_req_o ? be_q    : 4'b0000;
  assign mem_wdata_o = mem_req_o ? wdata_q : '0;

  // Pipeline side: a flush in the response cycle still swallows completion.
  assign done_o      = (state_q == ST_RESP) && !kill_q && !kill_i;
  assign stall_o     = req_valid_i && !done_o;
  assign rdata_o     = done_o ? rdata_q : '0;
  assign err_o       = done_o && (err_q != ERR_NONE);
  assign err_code_o  = done_o ? err_q : ERR_NONE;

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the EX/MEM pipeline register and a variable-latency data memory. Replaces the fixed-latency `memory` hookup.
- Converts RV32I load/store requests (funct3 size/sign) into word-aligned bus transactions with byte enables. Extracts and extends load data.
- Raises stall while a transaction is outstanding and reports misaligned/illegal/timeout errors.

Parameters:
- XLEN, 32, data/address width
- TIMEOUT_CYCLES, 256, bus watchdog limit (used only with LSU_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  1  pipeline holds a load/store; held stable until done_o
- req_we_i  in  1  1=store, 0=load
- req_funct3_i  in  3  RV32I size/sign field
- req_addr_i  in  XLEN  byte address
- req_wdata_i  in  XLEN  store data (unaligned, LSB-justified)
- kill_i  in  1  flush; suppresses completion of the current request
- stall_o  out  1  req_valid_i && !done_o (combinational)
- done_o  out  1  one-cycle completion pulse
- rdata_o  out  XLEN  extended load data, valid with done_o
- err_o  out  1  error flag, valid with done_o
- err_code_o  out  2  0 none, 1 misaligned, 2 illegal funct3, 3 bus timeout
- mem_req_o  out  1  bus request
- mem_we_o  out  1  bus write
- mem_addr_o  out  XLEN  word address, addr[1:0]=0
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  XLEN  lane-replicated write data
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  read data valid; earliest one cycle after gnt
- mem_rdata_i  in  XLEN  read data

Behaviour:
- Reset (async): state=IDLE. All outputs 0, rdata_o=0, err_code_o=0.
- FSM states: IDLE, REQ, WAIT_R, RESP.
- IDLE, req_valid_i=1:
  - illegal funct3 (loads 011/110/111; stores other than 000/001/010) -> RESP, err_code=2.
  - misaligned (half with addr[0]=1; word with addr[1:0]!=0) -> RESP, err_code=1. No bus traffic.
  - otherwise latch address/be/wdata -> REQ.
- REQ:
  - mem_req_o=1. Addr/we/be/wdata registered and stable until gnt.
  - On gnt: store -> RESP; load -> WAIT_R.
- WAIT_R: on mem_rvalid_i, register the extracted lane into rdata_o -> RESP.
- RESP: done_o=1 for exactly one cycle -> IDLE unconditionally. A new request is not sampled in RESP.
- Latency with zero-wait bus: store done_o 2 cycles after request sampled; load 3 cycles; error 1 cycle.
- Byte enables:
  - byte: 0001<<addr[1:0]
  - half: 0011<<addr[1:0]
  - word: 1111
- mem_wdata_o: byte replicated x4, half replicated x2, word as-is.
- Load extract: lane = rdata>>(8*addr[1:0]). LB/LH sign-extend; LBU/LHU zero-extend; LW passthrough.
- Stores: rdata_o=0.
- kill_i:
  - Sampled every cycle; sets a kill flag for the current transaction.
  - In IDLE, a killed request is not started.
  - Once mem_req_o is asserted, the bus handshake completes normally, but done_o is suppressed and the FSM returns to IDLE.
  - Flag clears in IDLE.
- Unexpected mem_rvalid_i (outside WAIT_R) and mem_gnt_i outside REQ: ignored.
- Reset mid-transaction: immediate IDLE, mem_req_o dropped. The bus is expected to be reset together.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - Counter (clog2(TIMEOUT_CYCLES) bits) clears on entry to REQ/WAIT_R and increments each cycle there.
  - On reaching TIMEOUT_CYCLES-1 without gnt/rvalid: mem_req_o drops -> RESP with err_o=1, err_code=3.
- Undefined: no counter; waits indefinitely; err_code 3 never produced.

Decomposition:
- Package lsu_pkg: lsu_state_e, lsu_err_e (NONE/MISALIGN/ILLEGAL/TIMEOUT), funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
- Sub-module lsu_align (combinational): funct3+addr[1:0] -> be, replicated wdata, misaligned/illegal flags, load extract/extend. Reused by the FSM top.

Test Plan:
- SW 0xDEADBEEF @0x100, gnt in first REQ cycle -> mem_be_o=1111, mem_addr_o=0x100, done_o 2 cycles after req_valid_i, err_o=0.
- LB @0x103, mem_rdata_i=0x80FF_FF7F -> be=1000, rdata_o=0xFFFF_FF80. LBU same -> 0x0000_0080.
- SH 0x1234 @0x102, gnt delayed 3 cycles -> mem_wdata_o=0x1234_1234, be=1100, signals stable over all 4 REQ cycles, stall_o high until done_o.
- LW @0x101 -> done_o next cycle, err_o=1, err_code=1, mem_req_o never asserted. LH funct3=011 -> err_code=2.
- LHU @0x202, kill_i pulsed in WAIT_R -> rvalid consumed, done_o never asserts, FSM in IDLE next cycle.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=8, gnt never asserted -> mem_req_o drops after 8 cycles, done_o with err_code=3. Without the macro -> stall_o held indefinitely.
